// File: rtl/dct_transpose8x8.sv
`default_nettype none
// ============================================================================
// Module      : dct_transpose8x8
// Description : Ping-pong 8x8 transpose buffer sitting between the row and
//               column passes of a 2-D DCT. Rows are written into one bank
//               while columns of the previously completed block are read out
//               of the other bank, so the block runs at one row in and one
//               column out per cycle in steady state. Data is passed through
//               bit-exact.
//
// Ports       : clk       - single clock, all state changes on rising edge
//               rst       - synchronous active-high reset
//               in_valid  - row valid from the upstream row DCT
//               in_ready  - block can accept a row
//               in_data   - one row, lane k at [DATA_W*k +: DATA_W]
//               out_valid - a column is presented downstream
//               out_ready - downstream accepts the column
//               out_data  - one column, same lane packing as in_data
//               out_last  - high while column 7 of a block is presented
//
// Revision    : 1.0 - initial release
// ============================================================================
module dct_transpose8x8 #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*DATA_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*DATA_W-1:0] out_data,
    output logic                out_last
);

    localparam logic [2:0] c_LAST_IDX = 3'd7;

    // Two 8x8 banks, indexed [bank][row][column]. Deliberately not reset:
    // the full flags alone decide whether a bank's contents are meaningful.
    logic [DATA_W-1:0] r_mem [2][8][8];

    logic       r_wb;        // bank currently being written
    logic       r_rb;        // bank currently being read
    logic [2:0] r_wr_cnt;    // next row to write
    logic [2:0] r_rd_cnt;    // column currently presented
    logic [1:0] r_full;      // per-bank full flag

    logic       w_wr_fire;
    logic       w_rd_fire;
    logic [1:0] w_full_nxt;

    // The write bank can only be full when both banks hold complete blocks,
    // so this deasserts exactly when the buffer has no free space.
    assign in_ready  = ~r_full[r_wb];
    assign out_valid = r_full[r_rb];
    assign out_last  = r_full[r_rb] && (r_rd_cnt == c_LAST_IDX);

    assign w_wr_fire = in_valid  && in_ready;
    assign w_rd_fire = out_valid && out_ready;

    // A write-side set and a read-side clear always target different banks
    // (writes only into an empty bank, reads only from a full one), so both
    // updates can be applied to the same next-state vector.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_fire && (r_rd_cnt == c_LAST_IDX)) begin
            w_full_nxt[r_rb] = 1'b0;
        end
        if (w_wr_fire && (r_wr_cnt == c_LAST_IDX)) begin
            w_full_nxt[r_wb] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb     <= 1'b0;
            r_rb     <= 1'b0;
            r_wr_cnt <= 3'd0;
            r_rd_cnt <= 3'd0;
            r_full   <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + 3'd1;     // wraps 7 -> 0
                if (r_wr_cnt == c_LAST_IDX) begin
                    r_wb <= ~r_wb;
                end
            end
            if (w_rd_fire) begin
                r_rd_cnt <= r_rd_cnt + 3'd1;     // wraps 7 -> 0
                if (r_rd_cnt == c_LAST_IDX) begin
                    r_rb <= ~r_rb;
                end
            end
        end
    end

    // Row write: lane k of the incoming row lands in column k.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[r_wb][r_wr_cnt][k] <= in_data[DATA_W*k +: DATA_W];
            end
        end
    end

    // Column read: lane k of the output is row k of the current column.
    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign out_data[DATA_W*k +: DATA_W] =
            r_full[r_rb] ? r_mem[r_rb][k][r_rd_cnt] : {DATA_W{1'b0}};
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_transpose8x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_transpose8x8
// Description : Directed and randomised-handshake bench for dct_transpose8x8.
//               A reference queue of expected columns is built from the rows
//               the bench sends and is compared against the output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_transpose8x8;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [8*W-1:0] out_data;
    logic           out_last;

    always #5 clk = ~clk;

    dct_transpose8x8 #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int             n_chk  = 0;
    int             n_fail = 0;
    int             n_out  = 0;   // columns consumed (model view)
    int             n_acc  = 0;   // rows accepted (model view)
    logic [8*W-1:0] exp_q[$];     // expected columns still to be emitted
    logic [8*W-1:0] rows[8];      // rows of the block being assembled
    int             n_rows = 0;

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Blocks not yet fully drained; the buffer has room while fewer than two.
    function automatic bit m_ready();
        return ((exp_q.size() + 7) / 8) < 2;
    endfunction

    // One clock cycle: check outputs against the model, advance the model on
    // the model's own handshakes, then step to #1 after the next rising edge.
    task automatic cycle();
        bit             mv;
        bit             mr;
        logic [8*W-1:0] col;
        mv = exp_q.size() > 0;
        mr = m_ready();
        chk("in_ready",  {127'd0, in_ready},  {127'd0, mr});
        chk("out_valid", {127'd0, out_valid}, {127'd0, mv});
        chk("out_last",  {127'd0, out_last},  {127'd0, (exp_q.size() % 8) == 1});
        if (mv) chk("out_data", out_data, exp_q[0]);
        else    chk("out_zero", out_data, '0);
        if (mv && out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
        end
        if (mr && in_valid) begin
            rows[n_rows] = in_data;
            n_rows++;
            n_acc++;
            if (n_rows == 8) begin
                for (int c = 0; c < 8; c++) begin
                    for (int k = 0; k < 8; k++) col[W*k +: W] = rows[k][W*c +: W];
                    exp_q.push_back(col);
                end
                n_rows = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n_rows = 0;
    endtask

    function automatic logic [8*W-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Send nrows random rows with pv% in_valid and pr% out_ready, then drain.
    task automatic run(input int nrows, input int pv, input int pr);
        int sent   = 0;
        int budget = 0;
        while ((sent < nrows || exp_q.size() > 0) && budget < 40000) begin
            in_valid  = (sent < nrows) && ($urandom_range(99) < pv);
            in_data   = rnd_row();
            out_ready = $urandom_range(99) < pr;
            if (in_valid && m_ready()) sent++;
            cycle();
            budget++;
        end
        in_valid = 1'b0;
        chk("run_done", 128'(nrows - sent + exp_q.size()), '0);
    endtask

    initial begin
        logic [8*W-1:0] v;
        int             out0;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        // Reset state
        do_reset();
        chk("rst_in_ready",  {127'd0, in_ready},  128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_last",  {127'd0, out_last},  128'd0);
        chk("rst_out_data",  out_data,            '0);

        // Basic transpose: row r lane k = 16r+k; column c lane k = 16k+c
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int k = 0; k < 8; k++) in_data[W*k +: W] = 16'(16 * r + k);
            cycle();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) v[W*k +: W] = 16'(16 * k + c);
            chk("basic_col",  out_data, v);
            chk("basic_last", {127'd0, out_last}, {127'd0, c == 7});
            cycle();
        end
        chk("basic_idle", {127'd0, out_valid}, 128'd0);

        // Back-pressure: 3 blocks offered with out_ready low, only 2 fit
        out_ready = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = rnd_row();
            cycle();
        end
        chk("bp_accepted", 128'(n_acc), 128'd16);
        chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
        out0 = n_out;
        run(8, 100, 100);
        chk("bp_drained", 128'(n_out - out0), 128'd24);

        // Streaming: in_valid and out_ready held high for 64 rows
        out_ready = 1'b1;
        out0      = n_out;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = rnd_row();
            chk("stream_ready", {127'd0, in_ready}, 128'd1);
            cycle();
        end
        chk("stream_cols", 128'(n_out - out0), 128'd56);
        run(0, 0, 100);

        // Sign/width: 0x8000 / 0xFFFF / 0x7FFF pattern
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int k = 0; k < 8; k++)
                in_data[W*k +: W] = ((r + k) % 2 == 1) ? 16'h8000 :
                                    ((r == 3 && k == 1) ? 16'h7FFF : 16'hFFFF);
            cycle();
        end
        in_valid = 1'b0;
        // column 0: lanes alternate FFFF/8000
        chk("sign_col0", out_data, {16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF,
                                    16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF});
        cycle();
        // column 1: row 3 lane 1 = 7FFF lands in lane 3
        chk("sign_col1", out_data, {16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000,
                                    16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000});
        run(0, 0, 100);

        // Reset mid-operation: 5 rows of block A, then reset, then block B
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            in_valid = 1'b1;
            in_data  = {8{16'hAAAA}};
            cycle();
        end
        do_reset();
        chk("mid_in_ready",  {127'd0, in_ready},  128'd1);
        chk("mid_out_valid", {127'd0, out_valid}, 128'd0);
        chk("mid_out_data",  out_data,            '0);
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int k = 0; k < 8; k++) in_data[W*k +: W] = 16'(16'hB000 + 16 * r + k);
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) v[W*k +: W] = 16'(16'hB000 + 16 * k);
        chk("mid_b_col0", out_data, v);
        run(0, 0, 100);

        // Random stall: 100 blocks with random valid/ready
        out0 = n_out;
        run(800, 70, 60);
        chk("rand_cols", 128'(n_out - out0), 128'd800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dct_transpose8x8.md
DCT_TRANSPOSE8X8 -- requirements
Module: dct_transpose8x8

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the width of one coefficient lane.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream row-DCT result valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a row.
REQ-006 The block SHALL have port in_data, input, 8*DATA_W bits: one row; lane k at bits [DATA_W*k+DATA_W-1 : DATA_W*k].
REQ-007 The block SHALL have port out_valid, output, 1 bit: a column is presented to the downstream column DCT.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accepts the column.
REQ-009 The block SHALL have port out_data, output, 8*DATA_W bits: one column, with the same lane packing as in_data.
REQ-010 The block SHALL have port out_last, output, 1 bit: high while column 7 of a block is presented.

Function
REQ-011 Rows SHALL be accepted on cycles where in_valid && in_ready; columns SHALL be consumed on cycles where out_valid && out_ready.
REQ-012 Storage SHALL be two 8x8 banks of DATA_W-bit words (ping-pong), each with a full flag, plus a write-bank pointer, 3-bit write-row counter, read-bank pointer and 3-bit read-column counter.
REQ-013 in_ready SHALL equal NOT full[write bank], combinational from registers only, with no dependence on in_valid.
REQ-014 An accepted row SHALL be written to bank[wb] row wr_cnt, lane k into column k, after which wr_cnt increments.
REQ-015 On acceptance with wr_cnt==7, the block SHALL set full[wb], toggle wb, and wrap wr_cnt to 0.
REQ-016 out_valid SHALL equal full[read bank].
REQ-017 While out_valid is high, out_data lane k SHALL equal bank[rb] row k, column rd_cnt.
REQ-018 While out_valid is low, out_data SHALL be all zeros.
REQ-019 out_last SHALL equal out_valid && (rd_cnt==7).
REQ-020 On consumption, rd_cnt SHALL increment; when rd_cnt==7, the block SHALL clear full[rb], toggle rb, and wrap rd_cnt to 0.
REQ-021 Latency: after the edge that accepts row 7, out_valid SHALL be high in the following cycle and column 0 SHALL be presented.
REQ-022 Stall: while out_valid && !out_ready, out_data, out_last and rd_cnt SHALL hold unchanged.
REQ-023 Simultaneous events: a write-side set of one bank's full flag and a read-side clear of the other bank's full flag in the same cycle SHALL both take effect; a bank is never written while full nor read while empty.
REQ-024 Throughput: with out_ready held high and in_valid held high, in_ready SHALL never deassert, giving one row in and one column out per cycle in steady state.
REQ-025 in_ready SHALL deassert only when both banks are full.
REQ-026 Rows presented while in_ready is low SHALL be ignored and SHALL not advance any counter.
REQ-027 Values SHALL be passed bit-exact with no arithmetic, rounding or sign change.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL clear wb, rb, wr_cnt, rd_cnt and both full flags to 0.
REQ-029 After reset: in_ready=1, out_valid=0, out_last=0, out_data=0.
REQ-030 Bank contents SHALL not be reset.
REQ-031 Reset mid-block SHALL discard all partially written and unread data.
REQ-032 The first row accepted after reset SHALL start a new block in bank 0, row 0.

Verification
REQ-033 Basic transpose: send 8 rows, row r lane k = 16*r+k, out_ready=1 -> out_valid rises the cycle after row 7; columns c=0..7 output lane k = 16*k+c; out_last high only on c=7.
REQ-034 Back-pressure: 3 blocks back-to-back with out_ready=0 -> in_ready drops after 16 rows; no row 17 accepted; out_data is constant column 0 of block 0; raising out_ready drains 24 columns in order.
REQ-035 Streaming: in_valid=1 and out_ready=1 for 64 rows -> in_ready stays 1; 56 columns emitted by the final input cycle; all values match the transpose.
REQ-036 Random stall: random in_valid/out_ready over 100 blocks -> the output column stream equals the reference transpose with no loss or duplication.
REQ-037 Reset mid-operation: assert rst after 5 rows of block A -> next cycle in_ready=1, out_valid=0, out_data=0; a following block B outputs only B data.
REQ-038 Sign/width: rows containing 0x8000 and 0xFFFF -> values reappear bit-exact in the transposed positions.
